clock_divider_prog: RTL and testbench

//  Runtime-programmable integer clock divider producing a divided clock-enable waveform and a period tick.

---
 rtl/clock_divider_prog.sv | 124 ++++++++++++
 tb/tb_clock_divider_prog.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/clock_divider_prog.sv
// Runtime-programmable integer clock divider: divided waveform (clock_out) plus a
// period-start tick. Outputs are registered and lag the internal counter by 1 cycle.
// One config slot: cfg_ready drops while a config waits for the next period boundary.
//
// Ports:
//   clock_in  - single clock, all logic on posedge
//   reset     - synchronous, active-high
//   enable    - 1 = run; 0 = counter cleared, outputs low
//   cfg_valid/cfg_ready, cfg_div, cfg_high - new divisor / high-time offer
//   cfg_err   - 1-cycle pulse when an accepted config had cfg_div == 0 (discarded)
//   clock_out - divided waveform, high while the period counter is below high-time
//   tick      - 1-cycle pulse on the first cycle of each period
module clock_divider_prog #(
  parameter int unsigned WIDTH        = 28,
  parameter int unsigned DEFAULT_DIV  = 2,
  parameter int unsigned DEFAULT_HIGH = DEFAULT_DIV / 2
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             enable,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_div,
  input  logic [WIDTH-1:0] cfg_high,
  output logic             cfg_err,
  output logic             clock_out,
  output logic             tick
);

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] DIV_RST  = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] HIGH_RST = WIDTH'(DEFAULT_HIGH);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_a_q, div_a_d;
  logic [WIDTH-1:0] high_a_q, high_a_d;
  logic [WIDTH-1:0] div_p_q, div_p_d;
  logic [WIDTH-1:0] high_p_q, high_p_d;
  logic             pend_q, pend_d;
  logic             clock_out_q, clock_out_d;
  logic             tick_q, tick_d;
  logic             cfg_err_q, cfg_err_d;

  logic             bnd;
  logic             accept;

  assign cfg_ready = ~pend_q;
  assign accept    = cfg_valid & ~pend_q;
  // div_a is never 0, so div_a-1 cannot underflow.
  assign bnd       = (cnt_q >= div_a_q - ONE);

  always_comb begin
    cnt_d       = cnt_q;
    div_a_d     = div_a_q;
    high_a_d    = high_a_q;
    div_p_d     = div_p_q;
    high_p_d    = high_p_q;
    pend_d      = pend_q;
    clock_out_d = 1'b0;
    tick_d      = 1'b0;
    cfg_err_d   = 1'b0;

    if (enable) begin
      cnt_d       = bnd ? '0 : cnt_q + ONE;
      clock_out_d = (cnt_q < high_a_q);
      tick_d      = (cnt_q == '0);
      // Swap only at a period boundary so no partial period is ever emitted.
      if (bnd && pend_q) begin
        div_a_d  = div_p_q;
        high_a_d = high_p_q;
        pend_d   = 1'b0;
      end
    end else begin
      cnt_d = '0;
      // Nothing is being emitted while stopped, so a pending config can land at once.
      if (pend_q) begin
        div_a_d  = div_p_q;
        high_a_d = high_p_q;
        pend_d   = 1'b0;
      end
    end

    // accept implies pend_q==0, so this never collides with the load above;
    // an accept at a boundary therefore waits for the following boundary.
    if (accept) begin
      if (cfg_div == '0) begin
        cfg_err_d = 1'b1;
      end else begin
        div_p_d  = cfg_div;
        high_p_d = cfg_high;
        pend_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      cnt_q       <= '0;
      div_a_q     <= DIV_RST;
      high_a_q    <= HIGH_RST;
      div_p_q     <= '0;
      high_p_q    <= '0;
      pend_q      <= 1'b0;
      clock_out_q <= 1'b0;
      tick_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      div_a_q     <= div_a_d;
      high_a_q    <= high_a_d;
      div_p_q     <= div_p_d;
      high_p_q    <= high_p_d;
      pend_q      <= pend_d;
      clock_out_q <= clock_out_d;
      tick_q      <= tick_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign clock_out = clock_out_q;
  assign tick      = tick_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_clock_divider_prog.sv
module tb_clock_divider_prog;

  localparam int W = 28;

  logic         clk = 1'b0;
  logic         reset, enable, cfg_valid;
  logic         cfg_ready, cfg_err, clock_out, tick;
  logic [W-1:0] cfg_div, cfg_high;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clock_divider_prog #(.WIDTH(W), .DEFAULT_DIV(2), .DEFAULT_HIGH(1)) dut (
    .clock_in (clk),
    .reset    (reset),
    .enable   (enable),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_div  (cfg_div),
    .cfg_high (cfg_high),
    .cfg_err  (cfg_err),
    .clock_out(clock_out),
    .tick     (tick)
  );

  // Behavioural model: position inside the current period plus the active and
  // waiting (divisor, high-time) pairs; outputs derived directly from position.
  longint m_pos, m_div, m_high, p_div, p_high;
  bit     m_pend;
  bit     exp_co, exp_tick, exp_err;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit take;
    take    = cfg_valid && !m_pend;
    exp_err = 1'b0;
    if (reset) begin
      m_pos = 0; m_div = 2; m_high = 1; m_pend = 1'b0;
      exp_co = 1'b0; exp_tick = 1'b0;
    end else begin
      if (enable) begin
        exp_co   = (m_pos < m_high);
        exp_tick = (m_pos == 0);
        if (m_pos + 1 >= m_div) begin
          m_pos = 0;
          if (m_pend) begin m_div = p_div; m_high = p_high; m_pend = 1'b0; end
        end else begin
          m_pos = m_pos + 1;
        end
      end else begin
        exp_co = 1'b0; exp_tick = 1'b0; m_pos = 0;
        if (m_pend) begin m_div = p_div; m_high = p_high; m_pend = 1'b0; end
      end
      if (take) begin
        if (cfg_div == '0) exp_err = 1'b1;
        else begin p_div = longint'(cfg_div); p_high = longint'(cfg_high); m_pend = 1'b1; end
      end
    end
  endtask

  // One clock: model advances on the edge, DUT compared on the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("clock_out", clock_out, exp_co);
    check("tick", tick, exp_tick);
    check("cfg_err", cfg_err, exp_err);
    check("cfg_ready", cfg_ready, !m_pend);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (cfg_ready !== 1'b1 && n < 64) begin cycle(); n++; end
    if (n >= 64) check("ready_timeout", 0, 1);
  endtask

  task automatic wait_tick();
    int n = 0;
    do begin cycle(); n++; end while (tick !== 1'b1 && n < 64);
    if (tick !== 1'b1) check("tick_timeout", 0, 1);
  endtask

  task automatic send_cfg(input int d, input int h);
    wait_ready();
    cfg_div = W'(d); cfg_high = W'(h); cfg_valid = 1'b1;
    cycle();
    cfg_valid = 1'b0;
    wait_ready();
  endtask

  initial begin
    logic [3:0] h4, t4;
    logic [5:0] h6;
    logic [9:0] c10, t10;
    int ones, ticks, errs, n;

    reset = 1'b1; enable = 1'b0; cfg_valid = 1'b0; cfg_div = '0; cfg_high = '0;
    @(negedge clk);
    cycle();
    check("rst_ready", cfg_ready, 1);
    check("rst_clock_out", clock_out, 0);
    reset = 1'b0; enable = 1'b1;

    // Defaults: div 2 high 1, first high one cycle after enable.
    h4 = '0; t4 = '0;
    repeat (4) begin cycle(); h4 = {h4[2:0], clock_out}; t4 = {t4[2:0], tick}; end
    check("t1_co_pattern", h4, 4'b1010);
    check("t1_tick_pattern", t4, 4'b1010);

    // div 5 high 2.
    send_cfg(5, 2);
    wait_tick();
    c10 = {9'b0, clock_out}; t10 = {9'b0, tick};
    repeat (9) begin cycle(); c10 = {c10[8:0], clock_out}; t10 = {t10[8:0], tick}; end
    check("t2_co_pattern", c10, 10'b1100011000);
    check("t2_tick_pattern", t10, 10'b1000010000);

    // div 0 rejected.
    cfg_div = W'(0); cfg_high = W'(3); cfg_valid = 1'b1;
    cycle();
    errs = int'(cfg_err);
    cfg_valid = 1'b0;
    repeat (2) begin cycle(); errs += int'(cfg_err); end
    check("t3_err_pulses", errs, 1);
    check("t3_ready", cfg_ready, 1);

    // high 0 then high > div.
    send_cfg(4, 0);
    ones = 0; ticks = 0;
    repeat (8) begin cycle(); ones += int'(clock_out); ticks += int'(tick); end
    check("t4_low_ones", ones, 0);
    check("t4_low_ticks", ticks, 2);
    send_cfg(4, 7);
    ones = 0;
    repeat (8) begin cycle(); ones += int'(clock_out); end
    check("t4_high_ones", ones, 8);

    // div 1.
    send_cfg(1, 1);
    ones = 0; ticks = 0;
    repeat (4) begin cycle(); ones += int'(clock_out); ticks += int'(tick); end
    check("t5_div1_ones", ones, 4);
    check("t5_div1_ticks", ticks, 4);

    // Accept exactly on a boundary cycle of a div-3 period: waits a full period.
    send_cfg(3, 1);
    wait_tick();
    cycle();
    cfg_div = W'(5); cfg_high = W'(1); cfg_valid = 1'b1;
    cycle();
    cfg_valid = 1'b0;
    n = 0;
    while (cfg_ready !== 1'b1 && n < 64) begin cycle(); n++; end
    check("t5_bnd_accept_delay", n, 3);

    // Drop enable with a config pending.
    repeat (2) cycle();
    cfg_div = W'(6); cfg_high = W'(3); cfg_valid = 1'b1;
    cycle();
    cfg_valid = 1'b0; enable = 1'b0;
    cycle();
    check("t6_dis_co", clock_out, 0);
    check("t6_dis_tick", tick, 0);
    check("t6_dis_ready", cfg_ready, 1);
    enable = 1'b1;
    h6 = '0;
    repeat (6) begin cycle(); h6 = {h6[4:0], clock_out}; end
    check("t6_reenable_pattern", h6, 6'b111000);

    // Reset while pending.
    repeat (2) cycle();
    cfg_div = W'(7); cfg_high = W'(1); cfg_valid = 1'b1;
    cycle();
    cfg_valid = 1'b0;
    check("t6_pend_ready", cfg_ready, 0);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("t6_rst_ready", cfg_ready, 1);
    h4 = '0;
    repeat (4) begin cycle(); h4 = {h4[2:0], clock_out}; end
    check("t6_rst_defaults", h4, 4'b1010);

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      reset  = ($urandom_range(0, 499) == 0);
      enable = ($urandom_range(0, 9) != 0);
      if (!(cfg_valid && !cfg_ready)) begin
        cfg_valid = ($urandom_range(0, 3) == 0);
        cfg_div   = W'($urandom_range(0, 9));
        cfg_high  = W'($urandom_range(0, 11));
      end
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
